// File: rtl/stream_demux_2_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer and its per-port skid FIFOs.
package stream_demux_2_pkg;

    localparam int DEMUX_DEPTH = 2;
    localparam int NUM_PORTS   = 2;
    localparam int PTR_W       = 1;
    localparam int CNT_W       = 2;

    localparam logic SEL_P0 = 1'b0;
    localparam logic SEL_P1 = 1'b1;

    function automatic logic port_sel_code(input int port);
        return (port == 0) ? SEL_P0 : SEL_P1;
    endfunction

endpackage

// File: rtl/stream_demux_2_skid_fifo.sv
// 2-entry skid FIFO: registered head, no push-to-output bypass, sync flush.
module stream_skid_fifo
    import stream_demux_2_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          I_CLK,
    input  logic          I_RSTN,
    input  logic          I_FLUSH,
    input  logic          I_PUSH,
    input  logic [DW-1:0] I_DATA,
    output logic          O_VALID,
    input  logic          I_READY,
    output logic [DW-1:0] O_DATA,
    output logic          O_FULL
);

    logic [DEMUX_DEPTH-1:0][DW-1:0] mem;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [CNT_W-1:0]               count;
    logic                           push;
    logic                           pop;

    assign O_VALID = (count != '0);
    assign O_FULL  = (count == CNT_W'(DEMUX_DEPTH));
    assign O_DATA  = mem[rd_ptr];
    // A pop while full frees a slot only after the edge, so push never sees it.
    assign push    = I_PUSH & ~O_FULL;
    assign pop     = O_VALID & I_READY;

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (I_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= I_DATA;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux_2.sv
// 1-to-2 stream demux: steers each accepted word into one of two independent skid FIFOs.
module stream_demux_2
    import stream_demux_2_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          I_CLK,
    input  logic          I_RSTN,
    input  logic          I_FLUSH,
    input  logic          I_VALID,
    input  logic          I_SEL,
    input  logic [DW-1:0] I_DATA,
    output logic          O_READY,
    output logic          O_VALID_0,
    output logic [DW-1:0] O_DATA_0,
    input  logic          I_READY_0,
    output logic          O_VALID_1,
    output logic [DW-1:0] O_DATA_1,
    input  logic          I_READY_1
);

    logic [NUM_PORTS-1:0]         full;
    logic [NUM_PORTS-1:0]         push;
    logic [NUM_PORTS-1:0]         vld;
    logic [NUM_PORTS-1:0]         rdy;
    logic [NUM_PORTS-1:0][DW-1:0] dout;

    // Ready depends only on registered fullness, never on the consumers' ready.
    assign O_READY = ~full[I_SEL] & ~I_FLUSH;

    assign rdy       = {I_READY_1, I_READY_0};
    assign O_VALID_0 = vld[0];
    assign O_VALID_1 = vld[1];
    assign O_DATA_0  = dout[0];
    assign O_DATA_1  = dout[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push[p] = I_VALID & O_READY & (I_SEL == port_sel_code(p));

        stream_skid_fifo #(.DW(DW)) u_fifo (
            .I_CLK   (I_CLK),
            .I_RSTN  (I_RSTN),
            .I_FLUSH (I_FLUSH),
            .I_PUSH  (push[p]),
            .I_DATA  (I_DATA),
            .O_VALID (vld[p]),
            .I_READY (rdy[p]),
            .O_DATA  (dout[p]),
            .O_FULL  (full[p])
        );
    end

endmodule

// File: tb/tb_stream_demux_2.sv
// Directed self-checking bench for stream_demux_2.
module tb_stream_demux_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        sel;
    logic [31:0] in_data;
    logic        out_ready;
    logic        valid_0, valid_1;
    logic [31:0] data_0, data_1;
    logic        ready_0, ready_1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux_2 #(.DW(32)) dut (
        .I_CLK     (clk),
        .I_RSTN    (rst_n),
        .I_FLUSH   (flush),
        .I_VALID   (in_valid),
        .I_SEL     (sel),
        .I_DATA    (in_data),
        .O_READY   (out_ready),
        .O_VALID_0 (valid_0),
        .O_DATA_0  (data_0),
        .I_READY_0 (ready_0),
        .O_VALID_1 (valid_1),
        .O_DATA_1  (data_1),
        .I_READY_1 (ready_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        sel      = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready_0 = 1'b1; ready_1 = 1'b1;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        step(); step();
        chk("rst_valid_0", {31'd0, valid_0}, 32'd0);
        chk("rst_valid_1", {31'd0, valid_1}, 32'd0);
        chk("rst_data_0", data_0, 32'd0);
        chk("rst_data_1", data_1, 32'd0);
        chk("rst_ready", {31'd0, out_ready}, 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_no_push", {31'd0, valid_0}, 32'd0);

        // Routing
        drive(1'b1, 1'b0, 32'hA5A5_A5A5);
        chk("route_ready0", {31'd0, out_ready}, 32'd1);
        chk("route_lat_0", {31'd0, valid_0}, 32'd0);
        step();
        chk("route_valid_0", {31'd0, valid_0}, 32'd1);
        chk("route_data_0", data_0, 32'hA5A5_A5A5);
        drive(1'b1, 1'b1, 32'h5A5A_5A5A);
        step();
        chk("route_pop_0", {31'd0, valid_0}, 32'd0);
        chk("route_valid_1", {31'd0, valid_1}, 32'd1);
        chk("route_data_1", data_1, 32'h5A5A_5A5A);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("route_pop_1", {31'd0, valid_1}, 32'd0);

        // Full / back-pressure on port 0; port 1 keeps flowing
        ready_0 = 1'b0;
        drive(1'b1, 1'b0, 32'h1); step();
        drive(1'b1, 1'b0, 32'h2); step();
        drive(1'b1, 1'b1, 32'h9);
        chk("full_p1_ready", {31'd0, out_ready}, 32'd1);
        step();
        chk("full_p1_data", data_1, 32'h9);
        chk("full_p1_valid", {31'd0, valid_1}, 32'd1);
        drive(1'b1, 1'b0, 32'h3);
        chk("full_p0_ready", {31'd0, out_ready}, 32'd0);
        chk("full_p0_head", data_0, 32'h1);
        step();
        chk("full_p0_hold", {31'd0, out_ready}, 32'd0);
        chk("full_p0_head2", data_0, 32'h1);

        // Full + pop same cycle: no bypass
        ready_0 = 1'b1;
        #1;
        chk("fpop_ready_now", {31'd0, out_ready}, 32'd0);
        step();
        chk("fpop_ready_next", {31'd0, out_ready}, 32'd1);
        chk("fpop_data_2", data_0, 32'h2);
        step();
        drive(1'b0, 1'b0, 32'h0);
        chk("fpop_data_3", data_0, 32'h3);
        chk("fpop_valid_3", {31'd0, valid_0}, 32'd1);
        step();
        chk("fpop_empty", {31'd0, valid_0}, 32'd0);

        // Streaming with pointer wrap
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i[0], 32'h100 + i);
            chk($sformatf("strm_ready_%0d", i), {31'd0, out_ready}, 32'd1);
            step();
            if (i[0]) begin
                chk($sformatf("strm_d1_%0d", i), data_1, 32'h100 + i);
                chk($sformatf("strm_v0_%0d", i), {31'd0, valid_0}, 32'd0);
            end else begin
                chk($sformatf("strm_d0_%0d", i), data_0, 32'h100 + i);
                chk($sformatf("strm_v1_%0d", i), {31'd0, valid_1}, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("strm_drain_0", {31'd0, valid_0}, 32'd0);
        chk("strm_drain_1", {31'd0, valid_1}, 32'd0);

        // Flush with a word presented
        ready_0 = 1'b0; ready_1 = 1'b0;
        drive(1'b1, 1'b0, 32'h11); step();
        drive(1'b1, 1'b0, 32'h22); step();
        drive(1'b1, 1'b1, 32'h33); step();
        chk("fl_pre_d0", data_0, 32'h11);
        chk("fl_pre_d1", data_1, 32'h33);
        flush = 1'b1;
        drive(1'b1, 1'b1, 32'h44);
        chk("fl_ready", {31'd0, out_ready}, 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("fl_valid_0", {31'd0, valid_0}, 32'd0);
        chk("fl_valid_1", {31'd0, valid_1}, 32'd0);
        chk("fl_ready_after", {31'd0, out_ready}, 32'd1);
        drive(1'b1, 1'b1, 32'h55); step();
        drive(1'b0, 1'b0, 32'h0);
        chk("fl_repush_d1", data_1, 32'h55);
        chk("fl_repush_v0", {31'd0, valid_0}, 32'd0);

        // Reset mid-transfer clears immediately
        rst_n = 1'b0;
        #1;
        chk("mrst_valid_1", {31'd0, valid_1}, 32'd0);
        chk("mrst_data_1", data_1, 32'd0);
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
